contador_gray_param: RTL

CONTADOR_GRAY_PARAM -- requirements
Module: contador_gray_param

---
 rtl/contador_gray_param.sv | 94 +++++++++
 1 files changed

// File: rtl/contador_gray_param.sv
// Modulo-MODULO up/down binary counter with a registered Gray-coded mirror.
// Loads take a Gray-coded value; loads at or above MODULO saturate to MODULO-1 and flag load_err.
module contador_gray_param #(
    parameter int WIDTH  = 5,
    parameter int MODULO = 32
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] count_bin,
    output logic [WIDTH-1:0] salida_gray,
    output logic             wrap,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] ZERO_VAL = '0;
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULO);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;
    logic             err_q;

    logic [WIDTH-1:0] load_bin;
    logic             load_over;
    logic [WIDTH-1:0] nxt_cnt;
    logic             nxt_wrap;
    logic             nxt_err;

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        load_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            load_bin[i] = ^(load_gray >> i);
        end
        load_over = ({1'b0, load_bin} >= MOD_EXT);
    end

    always_comb begin
        nxt_cnt  = cnt;
        nxt_wrap = 1'b0;
        nxt_err  = 1'b0;
        if (load) begin
            if (load_over) begin
                nxt_cnt = MAX_VAL;
                nxt_err = 1'b1;
            end else begin
                nxt_cnt = load_bin;
            end
        end else if (enable) begin
            if (up_down) begin
                if (cnt == MAX_VAL) begin
                    nxt_cnt  = ZERO_VAL;
                    nxt_wrap = 1'b1;
                end else begin
                    nxt_cnt = cnt + ONE_VAL;
                end
            end else begin
                if (cnt == ZERO_VAL) begin
                    nxt_cnt  = MAX_VAL;
                    nxt_wrap = 1'b1;
                end else begin
                    nxt_cnt = cnt - ONE_VAL;
                end
            end
        end
    end

    // Gray is registered from the next binary value so it never lags count_bin.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            cnt    <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt    <= nxt_cnt;
            gray_q <= nxt_cnt ^ (nxt_cnt >> 1);
            wrap_q <= nxt_wrap;
            err_q  <= nxt_err;
        end
    end

    assign count_bin   = cnt;
    assign salida_gray = gray_q;
    assign wrap        = wrap_q;
    assign load_err    = err_q;

endmodule
